weight_bram_writer: RTL and testbench



---
 rtl/weight_bram_pkg.sv | 14 +
 rtl/weight_packer.sv | 64 ++++++
 rtl/weight_bram_writer.sv | 139 +++++++++++++
 tb/tb_weight_bram_writer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_bram_pkg.sv
// Shared definitions for the weight-BRAM write path: weight/lane widths and FSM encodings.
package weight_bram_pkg;

  localparam int WEIGHT_WIDTH = 5;
  localparam int LANE_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/weight_packer.sv
// Collects MAC_NUM/LANES stream beats into one packed 5*MAC_NUM-bit BRAM word.
module weight_packer
  import weight_bram_pkg::*;
#(
  parameter int MAC_NUM = 256,
  parameter int LANES   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            accept,
  input  logic [LANE_WIDTH*LANES-1:0]     data,
  output logic [WEIGHT_WIDTH*MAC_NUM-1:0] word,
  output logic                            word_full
);

  localparam int BEATS  = MAC_NUM / LANES;
  localparam int BEAT_W = WEIGHT_WIDTH * LANES;
  localparam int WORD_W = WEIGHT_WIDTH * MAC_NUM;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  beat_cnt;

  always_comb begin
    beat = '0;
    for (int l = 0; l < LANES; l++)
      beat[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] = data[l*LANE_WIDTH +: WEIGHT_WIDTH];
  end

  // Shift register: each new beat enters at the top, so after a full word
  // beat 0 has drifted down to the lowest weight indices. The packed word is
  // presented combinationally so the last beat lands in the same cycle.
  generate
    if (BEATS > 1) begin : g_shift
      logic [WORD_W-BEAT_W-1:0] older;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          older <= '0;
        else if (clear)
          older <= '0;
        else if (accept)
          older <= word[WORD_W-1:BEAT_W];
      end

      assign word = {beat, older};
    end else begin : g_single
      assign word = beat;
    end
  endgenerate

  assign word_full = (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beat_cnt <= '0;
    else if (clear)
      beat_cnt <= '0;
    else if (accept)
      beat_cnt <= word_full ? '0 : beat_cnt + 1'b1;
  end

endmodule

// File: rtl/weight_bram_writer.sv
// Packs a weight stream into BRAM words and writes them alternately to BRAM A and B.
// Optional tlast checking is enabled with WEIGHT_BRAM_WRITER_TLAST_CHECK_EN.
//
// state    | meaning
// ST_IDLE  | waiting for cfg_start, stream not consumed
// ST_PACK  | accepting beats into the packer
// ST_WRITE | one cycle after a word is strobed; advance word index
// ST_DONE  | one-cycle done pulse, then back to idle
module weight_bram_writer
  import weight_bram_pkg::*;
#(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int LANES              = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_start,
  input  logic [BRAM_ADDRESS_WIDTH:0]     cfg_word_count,
  input  logic [LANE_WIDTH*LANES-1:0]     s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_A,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_B,
  output logic [WEIGHT_WIDTH*MAC_NUM-1:0] bram_din_A,
  output logic [WEIGHT_WIDTH*MAC_NUM-1:0] bram_din_B,
  output logic                            bram_we_A,
  output logic                            bram_we_B,
  output logic                            busy,
  output logic                            done,
  output logic                            err_tlast
);

  localparam int AW = BRAM_ADDRESS_WIDTH;

  state_t                          state;
  logic [AW:0]                     count_q;
  logic [AW:0]                     n_idx;
  logic [AW:0]                     n_next;
  logic [WEIGHT_WIDTH*MAC_NUM-1:0] word;
  logic                            word_full;
  logic                            accept;
  logic                            start;

  assign n_next = n_idx + 1'b1;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign start  = (state == ST_IDLE) & cfg_start;

  weight_packer #(
    .MAC_NUM (MAC_NUM),
    .LANES   (LANES)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .accept    (accept),
    .data      (s_axis_tdata),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      count_q        <= '0;
      n_idx          <= '0;
      s_axis_tready  <= 1'b0;
      bram_address_A <= '0;
      bram_address_B <= '0;
      bram_din_A     <= '0;
      bram_din_B     <= '0;
      bram_we_A      <= 1'b0;
      bram_we_B      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_tlast      <= 1'b0;
    end else begin
      bram_we_A <= 1'b0;
      bram_we_B <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            count_q   <= cfg_word_count;
            n_idx     <= '0;
            err_tlast <= 1'b0;
            busy      <= 1'b1;
            // An empty load takes the WRITE slot without a strobe so done
            // keeps its fixed one-cycle lag behind the (absent) last write.
            if (cfg_word_count == '0) begin
              state <= ST_WRITE;
            end else begin
              state         <= ST_PACK;
              s_axis_tready <= 1'b1;
            end
          end
        end
        ST_PACK: begin
          if (accept) begin
`ifdef WEIGHT_BRAM_WRITER_TLAST_CHECK_EN
            if (s_axis_tlast != (word_full && (n_next == count_q)))
              err_tlast <= 1'b1;
`endif
            if (word_full) begin
              s_axis_tready <= 1'b0;
              state         <= ST_WRITE;
              if (!n_idx[0]) begin
                bram_we_A      <= 1'b1;
                bram_address_A <= n_idx[AW:1];
                bram_din_A     <= word;
              end else begin
                bram_we_B      <= 1'b1;
                bram_address_B <= n_idx[AW:1];
                bram_din_B     <= word;
              end
            end
          end
        end
        ST_WRITE: begin
          n_idx <= n_next;
          if (n_next >= count_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state         <= ST_PACK;
            s_axis_tready <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bram_writer.sv
// Directed self-checking bench for weight_bram_writer (MAC_NUM=16, LANES=8: 2 beats, 80-bit words).
module tb_weight_bram_writer;

  localparam int MAC_NUM = 16;
  localparam int LANES   = 8;
  localparam int AW      = 12;
  localparam int WW      = 5 * MAC_NUM;
  localparam int DW      = 8 * LANES;

`ifdef WEIGHT_BRAM_WRITER_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW:0]   cfg_word_count = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [AW-1:0] bram_address_A, bram_address_B;
  logic [WW-1:0] bram_din_A, bram_din_B;
  logic          bram_we_A, bram_we_B;
  logic          busy, done, err_tlast;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    bit            port;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t wlog[$];

  weight_bram_writer #(
    .MAC_NUM            (MAC_NUM),
    .BRAM_ADDRESS_WIDTH (AW),
    .LANES              (LANES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_word_count (cfg_word_count),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .bram_address_A (bram_address_A),
    .bram_address_B (bram_address_B),
    .bram_din_A     (bram_din_A),
    .bram_din_B     (bram_din_B),
    .bram_we_A      (bram_we_A),
    .bram_we_B      (bram_we_B),
    .busy           (busy),
    .done           (done),
    .err_tlast      (err_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat with lane l weight = seed + l*step; upper lane bits set to junk.
  function automatic logic [DW-1:0] make_beat(input int seed, input int step);
    logic [DW-1:0] d;
    d = '0;
    for (int l = 0; l < LANES; l++)
      d[8*l +: 8] = {3'b111, 5'((seed + l * step) & 31)};
    return d;
  endfunction

  function automatic logic [WW-1:0] exp_word(input int s0, input int s1, input int step);
    logic [WW-1:0] w;
    int sd;
    w = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      sd = (i < LANES) ? s0 : s1;
      w[5*i +: 5] = 5'((sd + (i % LANES) * step) & 31);
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", bram_we_A & bram_we_B, 1'b0);
      if (bram_we_A | bram_we_B) check("tready_in_write", s_axis_tready, 1'b0);
      if (!busy) check("tready_in_idle", s_axis_tready, 1'b0);
      if (bram_we_A) wlog.push_back('{1'b0, bram_address_A, bram_din_A, cyc});
      if (bram_we_B) wlog.push_back('{1'b1, bram_address_B, bram_din_B, cyc});
      if (done) done_cnt++;
    end
  end

  task automatic start_load(input int cnt);
    cfg_start      = 1'b1;
    cfg_word_count = (AW+1)'(cnt);
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int gap);
    bit got;
    s_axis_tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = s_axis_tready;
      @(posedge clk); #1;
    end
    check("beat_accept", got, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; dcyc = cyc; end
    end
    check("done_seen", seen, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tready"}, s_axis_tready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_we"}, {bram_we_A, bram_we_B}, 2'b00);
    check({tag, "_addr_A"}, bram_address_A, '0);
    check({tag, "_addr_B"}, bram_address_B, '0);
    check({tag, "_din_A"}, bram_din_A, '0);
    check({tag, "_din_B"}, bram_din_B, '0);
    check({tag, "_err"}, err_tlast, 1'b0);
  endtask

  initial begin
    int dc;
    int sd2[8];
    int sd3[6];
    int st3[3];

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // count=1, weights 0..15
    wlog.delete(); done_cnt = 0;
    start_load(1);
    @(negedge clk);
    check("t1_busy_start", busy, 1'b1);
    check("t1_tready_start", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    send_beat(make_beat(0, 1), 1'b0, 0);
    send_beat(make_beat(8, 1), 1'b1, 0);
    @(negedge clk);
    check("t1_we_A", bram_we_A, 1'b1);
    check("t1_we_B", bram_we_B, 1'b0);
    check("t1_addr_A", bram_address_A, 12'd0);
    check("t1_din_A", bram_din_A, exp_word(0, 8, 1));
    check("t1_din_lo", bram_din_A[4:0], 5'd0);
    check("t1_din_hi", bram_din_A[79:75], 5'd15);
    check("t1_done_early", done, 1'b0);
    @(negedge clk);
    check("t1_done", done, 1'b1);
    check("t1_we_A_off", bram_we_A, 1'b0);
    check("t1_busy_in_done", busy, 1'b1);
    @(negedge clk);
    check("t1_done_off", done, 1'b0);
    check("t1_busy_off", busy, 1'b0);
    check("t1_nwrites", wlog.size(), 1);
    check("t1_done_cnt", done_cnt, 1);
    @(posedge clk); #1;

    // count=4, continuous beats
    sd2 = '{2, 30, 7, 13, 19, 25, 4, 11};
    wlog.delete(); done_cnt = 0;
    start_load(4);
    for (int b = 0; b < 8; b++) send_beat(make_beat(sd2[b], 3), b == 7, 0);
    wait_done(dc);
    check("t2_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check("t2_port", wlog[j].port, j % 2);
        check("t2_addr", wlog[j].addr, j / 2);
        check("t2_data", wlog[j].data, exp_word(sd2[2*j], sd2[2*j+1], 3));
      end
      check("t2_throughput", wlog[1].cyc - wlog[0].cyc, 3);
      check("t2_done_lag", dc, wlog[3].cyc + 1);
    end
    check("t2_done_cnt", done_cnt, 1);
    check("t2_err", err_tlast, 1'b0);

    // reset after one beat of a load
    start_load(1);
    send_beat(make_beat(1, 1), 1'b0, 0);
    rst = 1'b1;
    #1;
    check_outputs_zero("t3_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    wlog.delete(); done_cnt = 0;
    start_load(1);
    send_beat(make_beat(10, 2), 1'b0, 0);
    send_beat(make_beat(20, 2), 1'b1, 0);
    wait_done(dc);
    check("t3_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("t3_port", wlog[0].port, 1'b0);
      check("t3_addr", wlog[0].addr, 12'd0);
      check("t3_data", wlog[0].data, exp_word(10, 20, 2));
    end
    check("t3_done_cnt", done_cnt, 1);

    // count=3 with random tvalid gaps
    sd3 = '{3, 17, 5, 9, 21, 30};
    st3 = '{3, 7, 11};
    wlog.delete(); done_cnt = 0;
    start_load(3);
    for (int b = 0; b < 6; b++)
      send_beat(make_beat(sd3[b], st3[b/2]), b == 5, int'($urandom_range(0, 3)));
    wait_done(dc);
    check("t4_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        check("t4_port", wlog[j].port, j % 2);
        check("t4_addr", wlog[j].addr, j / 2);
        check("t4_data", wlog[j].data, exp_word(sd3[2*j], sd3[2*j+1], st3[j]));
      end
    end
    check("t4_done_cnt", done_cnt, 1);
    check("t4_err", err_tlast, 1'b0);

    // count=0
    wlog.delete(); done_cnt = 0;
    start_load(0);
    @(negedge clk);
    check("t5_busy", busy, 1'b1);
    check("t5_done_t1", done, 1'b0);
    check("t5_tready", s_axis_tready, 1'b0);
    @(negedge clk);
    check("t5_done_t2", done, 1'b1);
    @(negedge clk);
    check("t5_busy_off", busy, 1'b0);
    check("t5_done_off", done, 1'b0);
    check("t5_nwrites", wlog.size(), 0);
    @(posedge clk); #1;

    // cfg_start while busy is ignored
    wlog.delete(); done_cnt = 0;
    start_load(1);
    send_beat(make_beat(5, 1), 1'b0, 0);
    cfg_start = 1'b1;
    cfg_word_count = 13'd4;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    send_beat(make_beat(9, 1), 1'b1, 0);
    wait_done(dc);
    check("t6_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("t6_port", wlog[0].port, 1'b0);
      check("t6_addr", wlog[0].addr, 12'd0);
      check("t6_data", wlog[0].data, exp_word(5, 9, 1));
    end
    check("t6_done_cnt", done_cnt, 1);

    // count=2 with tlast on the third beat instead of the fourth
    wlog.delete(); done_cnt = 0;
    start_load(2);
    for (int b = 0; b < 4; b++) send_beat(make_beat(4 * b + 1, 5), b == 2, 0);
    wait_done(dc);
    check("t7_err", err_tlast, TLAST_CHK);
    check("t7_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t7_port1", wlog[1].port, 1'b1);
      check("t7_addr1", wlog[1].addr, 12'd0);
      check("t7_data1", wlog[1].data, exp_word(9, 13, 5));
    end
    start_load(0);
    @(negedge clk);
    check("t7_err_cleared", err_tlast, 1'b0);
    @(posedge clk); #1;
    wait_done(dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
